// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the request/valid handshake to
// instruction memory and presents one instruction per cycle to the IF/ID register.
module if_stage #(
   parameter int              size     = 32,
   parameter logic [size-1:0] RESET_PC = {size{1'b0}}
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            STALL,
   input  logic            BRANCH_TAKEN,
   input  logic [size-1:0] BRANCH_TARGET,
   output logic            imem_req,
   output logic [size-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [size-1:0] imem_rdata,
   output logic [size-1:0] PC_IF,
   output logic [size-1:0] idata_IF,
   output logic [size-1:0] adder_IF,
   output logic            IF_VALID,
   output logic            FLUSH_ID
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [size-1:0] pc;
   logic [size-1:0] skid_pc;
   logic [size-1:0] skid_data;
   logic [size-1:0] target_aligned;
   logic            buf_free;
   logic            unused_target_bits;

   function automatic logic [size-1:0] plus4(input logic [size-1:0] a);
      return a + {{(size-3){1'b0}}, 3'b100};
   endfunction

   assign buf_free           = !IF_VALID || !STALL;
   assign target_aligned     = {BRANCH_TARGET[size-1:2], 2'b00};
   assign unused_target_bits = ^BRANCH_TARGET[1:0];

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a branch with a request still in flight must drain it first
   always_comb begin
      next_state = state;
      case (state)
         FETCH: begin
            if (BRANCH_TAKEN) begin
               next_state = imem_valid ? FETCH : DRAIN;
            end else if (imem_valid && !buf_free) begin
               next_state = HOLD;
            end else begin
               next_state = FETCH;
            end
         end
         HOLD: begin
            if (BRANCH_TAKEN || !STALL) begin
               next_state = FETCH;
            end else begin
               next_state = HOLD;
            end
         end
         DRAIN: begin
            if (imem_valid) begin
               next_state = FETCH;
            end else begin
               next_state = DRAIN;
            end
         end
         default: next_state = FETCH;
      endcase
   end

   // Memory-side and flush outputs
   always_comb begin
      imem_req  = (state == FETCH);
      imem_addr = pc;
      FLUSH_ID  = BRANCH_TAKEN;
   end

   // Fetch PC, skid register and the registered output buffer
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc        <= RESET_PC;
         skid_pc   <= {size{1'b0}};
         skid_data <= {size{1'b0}};
         PC_IF     <= {size{1'b0}};
         idata_IF  <= {size{1'b0}};
         adder_IF  <= {size{1'b0}};
         IF_VALID  <= 1'b0;
      end else if (BRANCH_TAKEN) begin
         pc       <= target_aligned;
         IF_VALID <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_valid) begin
                  if (buf_free) begin
                     PC_IF    <= pc;
                     idata_IF <= imem_rdata;
                     adder_IF <= plus4(pc);
                     IF_VALID <= 1'b1;
                  end else begin
                     skid_pc   <= pc;
                     skid_data <= imem_rdata;
                  end
                  pc <= plus4(pc);
               end else if (!STALL) begin
                  IF_VALID <= 1'b0;
               end
            end
            HOLD: begin
               if (!STALL) begin
                  PC_IF    <= skid_pc;
                  idata_IF <= skid_data;
                  adder_IF <= plus4(skid_pc);
                  IF_VALID <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: a queue-based fetch model plus a latency-randomised
// memory responder, with directed scenarios and a second instance for PC wrap-around.
module tb_if_stage;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, branch, imem_valid;
   logic [31:0] target, imem_rdata;
   logic        imem_req, if_valid, flush_id;
   logic [31:0] imem_addr, pc_if, idata_if, adder_if;

   logic        b_rst_n, b_stall, b_branch, b_valid;
   logic [31:0] b_target, b_rdata;
   logic        b_req, b_if_valid, b_flush;
   logic [31:0] b_addr, b_pc_if, b_idata, b_adder;

   if_stage #(.size(32), .RESET_PC(RPC)) dut (
      .CLK(clk), .RESET_N(rst_n), .STALL(stall), .BRANCH_TAKEN(branch), .BRANCH_TARGET(target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .PC_IF(pc_if), .idata_IF(idata_if), .adder_IF(adder_if), .IF_VALID(if_valid), .FLUSH_ID(flush_id)
   );

   if_stage #(.size(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .CLK(clk), .RESET_N(b_rst_n), .STALL(b_stall), .BRANCH_TAKEN(b_branch), .BRANCH_TARGET(b_target),
      .imem_req(b_req), .imem_addr(b_addr), .imem_valid(b_valid), .imem_rdata(b_rdata),
      .PC_IF(b_pc_if), .idata_IF(b_idata), .adder_IF(b_adder), .IF_VALID(b_if_valid), .FLUSH_ID(b_flush)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A3C_96E1;
   endfunction

   assign b_rdata = word(b_addr);

   int errors = 0;
   int checks = 0;

   // behavioural model: fetch pointer, presented slot, at most one parked word, drain flag
   logic [31:0] m_pc, m_pc_if, m_data;
   bit          m_valid, m_drain;
   logic [63:0] skid[$];

   // memory responder state
   bit          outstanding;
   logic [31:0] maddr;
   int          mwait, wmin, wmax;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RPC; m_valid = 1'b0; m_pc_if = 32'h0; m_data = 32'h0;
      m_drain = 1'b0; skid.delete();
   endtask

   task automatic model_edge();
      bit fetching;
      if (!rst_n) begin
         model_reset();
      end else begin
         fetching = !m_drain && (skid.size() == 0);
         if (branch) begin
            m_drain = (fetching || m_drain) && !imem_valid;
            m_pc    = {target[31:2], 2'b00};
            m_valid = 1'b0;
            skid.delete();
         end else if (m_drain) begin
            if (imem_valid) m_drain = 1'b0;
         end else if (skid.size() != 0) begin
            if (!stall) begin
               {m_pc_if, m_data} = skid.pop_front();
               m_valid = 1'b1;
            end
         end else if (imem_valid) begin
            if (!m_valid || !stall) begin
               m_pc_if = m_pc; m_data = imem_rdata; m_valid = 1'b1;
            end else begin
               skid.push_back({m_pc, imem_rdata});
            end
            m_pc = m_pc + 32'd4;
         end else if (!stall) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk1("IF_VALID", if_valid, m_valid);
      chk1("imem_req", imem_req, !m_drain && (skid.size() == 0));
      chk("imem_addr", imem_addr, m_pc);
      chk1("FLUSH_ID", flush_id, branch);
      if (m_valid) begin
         chk("PC_IF", pc_if, m_pc_if);
         chk("idata_IF", idata_if, m_data);
         chk("adder_IF", adder_if, m_pc_if + 32'd4);
      end
   endtask

   task automatic mem_drive();
      if (!rst_n) begin
         outstanding = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
      end else begin
         if (outstanding && imem_req) chk("addr_stable", imem_addr, maddr);
         if (!outstanding && imem_req) begin
            outstanding = 1'b1;
            maddr = imem_addr;
            mwait = int'($urandom_range(wmax, wmin));
         end
         if (outstanding && mwait == 0) begin
            imem_valid = 1'b1; imem_rdata = word(maddr);
         end else begin
            imem_valid = 1'b0; imem_rdata = $urandom;
            if (outstanding) mwait--;
         end
      end
   endtask

   task automatic step(input bit st, input bit br, input logic [31:0] tg);
      stall = st; branch = br; target = tg;
      mem_drive();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (imem_valid) outstanding = 1'b0;
      compare();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
      imem_valid = 1'b0; imem_rdata = 32'h0; outstanding = 1'b0; wmin = 0; wmax = 0;
      b_rst_n = 1'b1; b_stall = 1'b0; b_branch = 1'b0; b_target = 32'h0; b_valid = 1'b1;
      model_reset();
      #1 rst_n = 1'b0; b_rst_n = 1'b0;
      @(negedge clk);
      chk("rst_PC_IF", pc_if, 32'h0);
      chk("rst_idata", idata_if, 32'h0);
      chk("rst_adder", adder_if, 32'h0);
      chk1("rst_IF_VALID", if_valid, 1'b0);
      chk1("rst_req", imem_req, 1'b1);
      chk("rst_addr", imem_addr, RPC);
      step(1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;

      // zero-wait stream
      step(1'b0, 1'b0, 32'h0);
      chk("zw_pc0", pc_if, 32'h0);
      chk("zw_adder0", adder_if, 32'h4);
      chk1("zw_valid0", if_valid, 1'b1);
      chk("zw_data0", idata_if, word(32'h0));
      step(1'b0, 1'b0, 32'h0);
      chk("zw_pc4", pc_if, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      chk("zw_pc8", pc_if, 32'h8);

      // three-cycle stall while the response for 12 arrives
      step(1'b1, 1'b0, 32'h0);
      chk("st_hold8", pc_if, 32'h8);
      chk1("st_req0", imem_req, 1'b0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("st_still8", pc_if, 32'h8);
      chk1("st_still_req0", imem_req, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      chk("st_pc12", pc_if, 32'hC);
      chk("st_adder16", adder_if, 32'h10);
      chk("st_data12", idata_if, word(32'hC));
      chk("st_addr16", imem_addr, 32'h10);
      step(1'b0, 1'b0, 32'h0);
      chk("st_pc16", pc_if, 32'h10);

      // two wait states: IF_VALID 0,0,1 repeating
      wmin = 2; wmax = 2;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 32'h0);
         chk1("w2_valid", if_valid, (k % 3) == 2);
         if (k == 2) chk("w2_pc20", pc_if, 32'h14);
         if (k == 5) chk("w2_pc24", pc_if, 32'h18);
      end

      // branch to 0x103 with the request for 0x20 outstanding
      n = 0;
      while (imem_addr !== 32'h20 && n < 20) begin
         step(1'b0, 1'b0, 32'h0);
         n++;
      end
      chk("reach_0x20", imem_addr, 32'h20);
      step(1'b0, 1'b0, 32'h0);
      chk1("br_pending_req", imem_req, 1'b1);
      step(1'b0, 1'b1, 32'h103);
      chk1("br_flush", flush_id, 1'b1);
      chk1("br_valid0", if_valid, 1'b0);
      chk1("br_drain_req0", imem_req, 1'b0);
      chk("br_pc100", imem_addr, 32'h100);
      step(1'b0, 1'b0, 32'h0);
      chk1("br_discard_valid0", if_valid, 1'b0);
      chk1("br_refetch_req", imem_req, 1'b1);
      wmin = 0; wmax = 0;
      step(1'b0, 1'b0, 32'h0);
      chk("br_target_pc", pc_if, 32'h100);
      chk("br_target_data", idata_if, word(32'h100));

      // branch and stall together on a response edge
      step(1'b1, 1'b1, 32'h200);
      chk1("bs_valid0", if_valid, 1'b0);
      chk1("bs_req", imem_req, 1'b1);
      chk("bs_addr", imem_addr, 32'h200);
      step(1'b0, 1'b0, 32'h0);
      chk("bs_pc", pc_if, 32'h200);
      chk1("bs_valid1", if_valid, 1'b1);

      // randomized traffic with a mid-run reset
      for (int i = 0; i < 2000; i++) begin
         if (i % 250 == 0) begin
            wmin = 0; wmax = int'($urandom_range(3, 0));
         end
         if (i == 1200) rst_n = 1'b0;
         if (i == 1202) rst_n = 1'b1;
         step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 7, $urandom);
      end

      // wrap-around instance
      b_rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("wr_pc0", b_pc_if, 32'hFFFF_FFF8);
      chk("wr_adder0", b_adder, 32'hFFFF_FFFC);
      chk1("wr_valid0", b_if_valid, 1'b1);
      chk("wr_data0", b_idata, word(32'hFFFF_FFF8));
      @(posedge clk); @(negedge clk);
      chk("wr_pc1", b_pc_if, 32'hFFFF_FFFC);
      chk("wr_adder1", b_adder, 32'h0);
      @(posedge clk); @(negedge clk);
      chk("wr_pc2", b_pc_if, 32'h0);
      chk("wr_adder2", b_adder, 32'h4);
      @(posedge clk); @(negedge clk);
      chk("wr_pc3", b_pc_if, 32'h4);
      chk1("wr_flush", b_flush, 1'b0);
      #1 b_rst_n = 1'b0;
      #1;
      chk("ar_pc", b_pc_if, 32'h0);
      chk("ar_idata", b_idata, 32'h0);
      chk("ar_adder", b_adder, 32'h0);
      chk1("ar_valid", b_if_valid, 1'b0);
      chk1("ar_req", b_req, 1'b1);
      chk("ar_addr", b_addr, 32'hFFFF_FFF8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC and the PC+4 adder, and runs a request/valid handshake to instruction memory. It presents `PC_IF`, `idata_IF` and `adder_IF` with a valid flag, and honours hazard stalls and branch redirects. It also produces the flush pulse that drives the IF/ID `CLEAR` input.

## Interface

**Parameters**
- `size`, default 32: datapath / address width.
- `RESET_PC`, default 0: fetch address after reset; low 2 bits must be 0.

**Ports**
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `STALL` in 1: hazard stall; the IF/ID register does not load this cycle.
- `BRANCH_TAKEN` in 1: redirect request from EX.
- `BRANCH_TARGET` in size: redirect address; bits [1:0] ignored.
- `imem_req` out 1: fetch request.
- `imem_addr` out size: fetch address; equals the internal `pc`.
- `imem_valid` in 1: response strobe; may assert in the same cycle as `imem_req`.
- `imem_rdata` in size: instruction word, valid with `imem_valid`.
- `PC_IF` out size: address of the presented instruction.
- `idata_IF` out size: presented instruction.
- `adder_IF` out size: `PC_IF + 4`.
- `IF_VALID` out 1: presented instruction is real; 0 means bubble.
- `FLUSH_ID` out 1: combinational copy of `BRANCH_TAKEN`; wired to IF/ID `CLEAR`.

## Operation

- **State**
  - `pc`: fetch address.
  - Output buffer: `PC_IF`, `idata_IF`, `adder_IF`, `IF_VALID`.
  - Skid register: pc, data.
  - FSM `{FETCH, HOLD, DRAIN}`.
- **Buffer free** condition: `!IF_VALID || !STALL`. IF/ID consumes the buffer at any edge with `STALL=0`.
- **FETCH:** `imem_req=1`, `imem_addr=pc`; address is held stable until `imem_valid` is sampled high.
  - `imem_valid` and buffer free: buffer ← {pc, rdata, pc+4}, `IF_VALID`←1, `pc`←pc+4, stay in FETCH.
  - `imem_valid` and buffer not free: skid ← {pc, rdata}, `pc`←pc+4, go to HOLD.
  - No `imem_valid` and `STALL=0`: `IF_VALID`←0 (bubble).
- **HOLD:** `imem_req=0`. When `STALL=0`: buffer ← skid (with `adder_IF` = skid pc+4), `IF_VALID`←1, go to FETCH.
- **BRANCH_TAKEN=1** has priority over `STALL` and all other events except reset. The following apply at the edge:
  - `pc` ← {BRANCH_TARGET[size-1:2], 2'b00}.
  - `IF_VALID`←0; skid discarded.
  - FETCH with `imem_valid=0` (request outstanding): go to DRAIN.
  - FETCH with `imem_valid=1`: response discarded, stay in FETCH.
  - HOLD or DRAIN: go to (or stay in) the path below — HOLD goes to FETCH; DRAIN stays in DRAIN.
- **DRAIN:** `imem_req=0`. Wait for `imem_valid`, discard the data, go to FETCH at the new `pc`. A further branch in DRAIN only updates `pc`.
- **Arithmetic:** PC+4 is modulo 2^size and wraps without flag (0xFFFF_FFFC → 0x0000_0000).
- **Reset values:**
  - `pc`=RESET_PC, FSM=FETCH.
  - `PC_IF`=0, `idata_IF`=0, `adder_IF`=0, `IF_VALID`=0.
  - `imem_req`=1 combinationally during and after reset.
  - `FLUSH_ID`=`BRANCH_TAKEN`.
- A reset asserted mid-request abandons the transaction. The memory must also be reset.

## Timing

- Zero-wait memory (`imem_valid` same cycle as `imem_req`): one instruction per cycle. The first `IF_VALID=1` appears at the first edge after reset release, with `PC_IF`=RESET_PC.
- N wait states give N bubble cycles per instruction.
- Redirect penalty (zero-wait):
  - The branch edge loads `pc`=target and clears the buffer.
  - The target instruction is presented at the following edge.
  - `FLUSH_ID` clears IF/ID in the branch cycle.
- Stall with a response arriving: at most one instruction is absorbed by the skid; no request is issued until the stall releases.
- All outputs except `imem_req`, `imem_addr` and `FLUSH_ID` are registered.

## Test plan

- **Reset then zero-wait stream:** `RESET_PC`=0, `imem_valid` always 1 → `PC_IF` = 0, 4, 8, … on consecutive edges; `adder_IF`=`PC_IF`+4; `IF_VALID`=1 from the first edge.
- **Two wait states:** response every 3rd cycle → `IF_VALID` pattern 1,0,0 repeating; `imem_addr` stable while `imem_req`=1.
- **Stall for 3 cycles with the buffer valid at PC=8 and a response for 12 arriving:** buffer holds 8; FSM enters HOLD; `imem_req`=0; on release, 12 is presented, then fetch resumes at 16.
- **Branch to 0x103 while a request at 0x20 is outstanding:** `FLUSH_ID`=1 that cycle; DRAIN discards the late 0x20 data; next `PC_IF`=0x100.
- **Branch and STALL in the same cycle at the same edge as `imem_valid`:** branch wins; data discarded; `IF_VALID`=0; next fetch at the target.
- **Wrap-around:** `RESET_PC`=0xFFFF_FFF8 → `PC_IF` = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 with `adder_IF`=0x0 at 0xFFFF_FFFC. Asserting `RESET_N`=0 mid-stream clears all outputs asynchronously.
